// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and constants for the performance window controller
package perf_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int FRAC_W_DEF = 8;

  localparam logic [CNT_W_DEF-1:0] CPI_SAT = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_DIV   = 3'd3,
    ST_DONE  = 3'd4
  } perf_state_t;

endpackage

// File: rtl/perf_div_serial.sv
// rtl/perf_div_serial.sv - restoring serial divider, one quotient bit per cycle
module perf_div_serial #(
  parameter int DVD_W = 40,
  parameter int DVS_W = 32,
  parameter int Q_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient,
  output logic             q_ovf
);

  localparam int CNT_BITS = $clog2(DVD_W + 1);

  logic [DVD_W-1:0]    q_q, q_d;
  logic [DVS_W-1:0]    rem_q, rem_d;
  logic [DVS_W-1:0]    dvs_q, dvs_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DVS_W:0]      trial;
  logic [DVS_W:0]      diff;

  // Dividend bits shift out of the top of q while quotient bits fill in from the bottom.
  assign trial = {rem_q, q_q[DVD_W-1]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    q_d    = q_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (clear) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      q_d    = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = CNT_BITS'(DVD_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = diff[DVS_W-1:0];
        q_d   = {q_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DVS_W-1:0];
        q_d   = {q_q[DVD_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_BITS'(1);
      if (cnt_q == CNT_BITS'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = q_q[Q_W-1:0];
  assign q_ovf    = |q_q[DVD_W-1:Q_W];

endmodule

// File: rtl/perf_window_ctrl.sv
// rtl/perf_window_ctrl.sv - measurement window FSM, saturating counters and CPI publication
module perf_window_ctrl
  import perf_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [CNT_W-1:0] cfg_instr_limit,
  input  logic             start_instr,
  input  logic             end_instr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] total_cycles,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cpi,
  output logic             cpi_valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] SAT = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  perf_state_t      state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] cpi_q, cpi_d;
  logic             cpi_valid_q, cpi_valid_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             go_div;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic             div_q_ovf;
  logic [CNT_W-1:0] div_quot;
  logic [CNT_W:0]   cyc_sum;
  logic [CNT_W:0]   ins_sum;

  assign cyc_sum = {1'b0, cycles_q} + {{CNT_W{1'b0}}, 1'b1};
  assign ins_sum = {1'b0, instr_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    instr_d     = instr_q;
    limit_d     = limit_q;
    cpi_d       = cpi_q;
    cpi_valid_d = cpi_valid_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    go_div      = 1'b0;
    div_start   = 1'b0;

    case (state_q)
      ST_ARMED: begin
        if (cfg_stop) begin
          go_div = 1'b1;
        end else if (start_instr) begin
          cycles_d = ONE;
          instr_d  = end_instr ? ONE : '0;
          state_d  = ST_RUN;
          go_div   = end_instr && (limit_q != '0) && (instr_d == limit_q);
        end
      end
      ST_RUN: begin
        if (cyc_sum[CNT_W]) overflow_d = 1'b1;
        else                cycles_d   = cyc_sum[CNT_W-1:0];
        if (end_instr) begin
          if (ins_sum[CNT_W]) overflow_d = 1'b1;
          else                instr_d    = ins_sum[CNT_W-1:0];
        end
        go_div = cfg_stop || (end_instr && (limit_q != '0) && (instr_d == limit_q));
      end
      ST_DIV: begin
        // A zero-instruction window never started the divider.
        if (instr_q == '0) begin
          cpi_d       = SAT;
          cpi_valid_d = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else if (div_done && !div_busy) begin
          cpi_d       = div_q_ovf ? SAT : div_quot;
          cpi_valid_d = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    // The divider loads the post-increment counts so the stop cycle is included.
    if (go_div) begin
      state_d   = ST_DIV;
      div_start = (instr_d != '0);
    end

    if (cfg_start) begin
      state_d     = ST_ARMED;
      cycles_d    = '0;
      instr_d     = '0;
      limit_d     = cfg_instr_limit;
      cpi_d       = '0;
      cpi_valid_d = 1'b0;
      overflow_d  = 1'b0;
      done_d      = 1'b0;
      div_start   = 1'b0;
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_RUN) || (state_d == ST_DIV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cycles_q    <= '0;
      instr_q     <= '0;
      limit_q     <= '0;
      cpi_q       <= '0;
      cpi_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      instr_q     <= instr_d;
      limit_q     <= limit_d;
      cpi_q       <= cpi_d;
      cpi_valid_q <= cpi_valid_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  perf_div_serial #(
    .DVD_W(CNT_W + FRAC_W),
    .DVS_W(CNT_W),
    .Q_W  (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .clear   (cfg_start),
    .dividend({cycles_d, {FRAC_W{1'b0}}}),
    .divisor (instr_d),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot),
    .q_ovf   (div_q_ovf)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign total_cycles = cycles_q;
  assign instr_count  = instr_q;
  assign cpi          = cpi_q;
  assign cpi_valid    = cpi_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_perf_window_ctrl.sv
// tb/tb_perf_window_ctrl.sv - directed self-checking bench for perf_window_ctrl
module tb_perf_window_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic        cfg_stop;
  logic [31:0] cfg_instr_limit;
  logic        start_instr;
  logic        end_instr;
  logic        busy;
  logic        done;
  logic [31:0] total_cycles;
  logic [31:0] instr_count;
  logic [31:0] cpi;
  logic        cpi_valid;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;

  perf_window_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_instr_limit(cfg_instr_limit),
    .start_instr    (start_instr),
    .end_instr      (end_instr),
    .busy           (busy),
    .done           (done),
    .total_cycles   (total_cycles),
    .instr_count    (instr_count),
    .cpi            (cpi),
    .cpi_valid      (cpi_valid),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic si, input logic ei, input logic stp);
    start_instr = si;
    end_instr   = ei;
    cfg_stop    = stp;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] limit);
    cfg_instr_limit = limit;
    cfg_start       = 1'b1;
    @(negedge clk);
    cfg_start       = 1'b0;
  endtask

  // k=1 is the cycle right after the stop edge; k=42 is the cycle after stop edge + 41.
  task automatic wait_done(output int first, output int count);
    start_instr = 1'b0;
    end_instr   = 1'b0;
    cfg_stop    = 1'b0;
    first = 0;
    count = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        count++;
        if (first == 0) first = k;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    cfg_instr_limit = '0;
    start_instr = 1'b0;
    end_instr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles", total_cycles, 0);
    chk("rst_instr", instr_count, 0);
    chk("rst_cpi", cpi, 0);
    chk("rst_valid", cpi_valid, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 cycles, 25 retirements, explicit stop
    pulse_start(32'd0);
    chk("t1_busy_rise", busy, 1);
    for (int i = 0; i < 100; i++) cyc(i == 0, (i % 4) == 3, i == 99);
    chk("t1_valid_in_div", cpi_valid, 0);
    wait_done(lat, pulses);
    chk("t1_latency", 32'(lat), 42);
    chk("t1_pulses", 32'(pulses), 1);
    chk("t1_cycles", total_cycles, 100);
    chk("t1_instr", instr_count, 25);
    chk("t1_cpi", cpi, 32'h400);
    chk("t1_valid", cpi_valid, 1);
    chk("t1_busy", busy, 0);
    chk("t1_ovf", overflow, 0);

    // instruction limit 10 auto-stops
    pulse_start(32'd10);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("t2_busy_div", busy, 1);
    wait_done(lat, pulses);
    chk("t2_latency", 32'(lat), 42);
    chk("t2_pulses", 32'(pulses), 1);
    chk("t2_cycles", total_cycles, 10);
    chk("t2_instr", instr_count, 10);
    chk("t2_cpi", cpi, 32'h100);

    // 7 cycles, 2 instructions -> 3.5
    pulse_start(32'd0);
    chk("t3_clr_valid", cpi_valid, 0);
    chk("t3_clr_cpi", cpi, 0);
    chk("t3_clr_cycles", total_cycles, 0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    wait_done(lat, pulses);
    chk("t3_cycles", total_cycles, 7);
    chk("t3_instr", instr_count, 2);
    chk("t3_cpi", cpi, 32'h380);

    // stop while still armed
    pulse_start(32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    wait_done(lat, pulses);
    chk("t4_latency", 32'(lat), 2);
    chk("t4_pulses", 32'(pulses), 1);
    chk("t4_cycles", total_cycles, 0);
    chk("t4_instr", instr_count, 0);
    chk("t4_cpi", cpi, 32'hFFFF_FFFF);
    chk("t4_ovf", overflow, 0);
    chk("t4_valid", cpi_valid, 1);

    // restart while dividing
    pulse_start(32'd0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    chk("t5_busy_div", busy, 1);
    pulse_start(32'd0);
    chk("t5_cycles_clr", total_cycles, 0);
    chk("t5_instr_clr", instr_count, 0);
    chk("t5_busy_armed", busy, 1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    wait_done(lat, pulses);
    chk("t5_latency", 32'(lat), 42);
    chk("t5_pulses", 32'(pulses), 1);
    chk("t5_cycles", total_cycles, 4);
    chk("t5_instr", instr_count, 4);
    chk("t5_cpi", cpi, 32'h100);

    // asynchronous reset mid-RUN
    pulse_start(32'd0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    chk("t6_run_cycles", total_cycles, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_run_cycles_rst", total_cycles, 0);
    chk("t6_run_instr_rst", instr_count, 0);
    chk("t6_run_busy_rst", busy, 0);
    chk("t6_run_valid_rst", cpi_valid, 0);
    chk("t6_run_cpi_rst", cpi, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // asynchronous reset mid-DIV
    pulse_start(32'd0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("t6_div_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_div_busy_rst", busy, 0);
    chk("t6_div_cycles_rst", total_cycles, 0);
    chk("t6_div_instr_rst", instr_count, 0);
    chk("t6_div_done_rst", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_done(lat, pulses);
    chk("t6_no_done", 32'(pulses), 0);
    chk("t6_idle", busy, 0);

    // strobes and stop ignored in IDLE
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t7_idle_busy", busy, 0);
    chk("t7_idle_cycles", total_cycles, 0);
    chk("t7_idle_instr", instr_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
